// File: rtl/bsg_async_ptr_consumer_if.sv
// Consumer-side bundle of an async FIFO pointer pair: synced write pointer in,
// read handshake and gray read pointer out. Master drives the inputs, slave is the consumer.
interface bsg_async_ptr_consumer_if #(
  parameter int unsigned lg_size_p = 3
);
  logic [lg_size_p:0]   w_ptr_gray_i;
  logic                 yumi_i;
  logic                 v_o;
  logic [lg_size_p-1:0] r_addr_o;
  logic [lg_size_p:0]   r_ptr_gray_o;
  logic [lg_size_p:0]   count_o;
  logic                 err_o;

  modport master (
    output w_ptr_gray_i,
    output yumi_i,
    input  v_o,
    input  r_addr_o,
    input  r_ptr_gray_o,
    input  count_o,
    input  err_o
  );

  modport slave (
    input  w_ptr_gray_i,
    input  yumi_i,
    output v_o,
    output r_addr_o,
    output r_ptr_gray_o,
    output count_o,
    output err_o
  );
endinterface

// File: rtl/bsg_async_ptr_consumer.sv
// Read-side pointer logic of an async FIFO: occupancy, valid, read address and gray read pointer.
// Optional protocol checker enabled by defining BSG_ASYNC_PTR_CONSUMER_CHECK_EN.
module bsg_async_ptr_consumer #(
  parameter int unsigned lg_size_p = 3
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bsg_async_ptr_consumer_if.slave ptr_io
);

  localparam int unsigned PtrW = lg_size_p + 1;

  logic [PtrW-1:0] w_gray_q;
  logic [PtrW-1:0] w_bin;
  logic [PtrW-1:0] r_bin_q, r_bin_d;
  logic [PtrW-1:0] r_gray_q, r_gray_d;
  logic [PtrW-1:0] count;
  logic            valid;
  logic            accept;

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      w_bin[i] = ^(w_gray_q >> i);
    end
  end

  always_comb begin
    count    = w_bin - r_bin_q;
    valid    = (count != '0);
    accept   = ptr_io.yumi_i & valid;
    r_bin_d  = r_bin_q + {{lg_size_p{1'b0}}, accept};
    r_gray_d = r_bin_d ^ (r_bin_d >> 1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_gray_q <= '0;
      r_bin_q  <= '0;
      r_gray_q <= '0;
    end else begin
      w_gray_q <= ptr_io.w_ptr_gray_i;
      r_bin_q  <= r_bin_d;
      r_gray_q <= r_gray_d;
    end
  end

`ifdef BSG_ASYNC_PTR_CONSUMER_CHECK_EN
  localparam logic [PtrW-1:0] Full = PtrW'(1) << lg_size_p;

  logic [PtrW-1:0] w_diff;
  logic            gray_jump;
  logic            err_set;
  logic            err_q;

  // A legal gray step changes zero or one bit; clearing the lowest set bit exposes any other.
  always_comb begin
    w_diff    = ptr_io.w_ptr_gray_i ^ w_gray_q;
    gray_jump = ((w_diff & (w_diff - PtrW'(1))) != '0);
    err_set   = gray_jump | (count > Full) | (ptr_io.yumi_i & ~valid);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign ptr_io.err_o = err_q;
`else
  assign ptr_io.err_o = 1'b0;
`endif

  assign ptr_io.v_o          = valid;
  assign ptr_io.count_o      = count;
  assign ptr_io.r_addr_o     = r_bin_q[lg_size_p-1:0];
  assign ptr_io.r_ptr_gray_o = r_gray_q;

endmodule
